fifo_burst_writer: RTL and testbench
====================================

Name: fifo_burst_writer

Overview:
- Write-side traffic source feeding the asynchronous FIFO write port (winc/wdata/wfull), entirely in the wclk domain.
- On a start pulse, issues one burst of BURST_LENGTH words with a fixed write spacing of WRITE_PERIOD cycles.
- Stalls whenever the FIFO reports full; never drops or duplicates a word.
- Reports completion, word count and stall cycles for bench scoreboarding and performance checks.

Parameters:
- DATASIZE, 8, width of wdata.
- BURST_LENGTH, 1024, words per burst; must be >= 1.
- WRITE_PERIOD, 2, cycles between successive accepted writes when not stalled; must be >= 1 (1 = back-to-back).
- SEED, 0, first data value of every burst.

Ports:
- wclk  in  1  write-domain clock, rising edge.
- wrst  in  1  reset: one clock; reset is synchronous and active-high.
- start  in  1  burst request; sampled only in IDLE.
- abort  in  1  terminates the burst in progress; no done pulse.
- wfull  in  1  FIFO full flag, wclk domain.
- winc  out  1  write enable to FIFO.
- wdata  out  DATASIZE  write data to FIFO.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst completion.
- word_count  out  $clog2(BURST_LENGTH+1)  words accepted in the current or last burst.
- stall_count  out  16  cycles spent in WRITE with wfull high, current or last burst; saturates at 0xFFFF.

Behaviour:
- Reset (wrst high at a wclk edge):
  - state = IDLE, data register = SEED, word_count = 0, stall_count = 0, done = 0.
  - winc is gated by !wrst combinationally, so it is 0 during any cycle with wrst high, including a reset asserted mid-burst.
- States: IDLE, WRITE, GAP, DONE.
- IDLE:
  - start=1 -> WRITE. On the same edge: data = SEED, word_count = 0, stall_count = 0.
  - start in any other state is ignored.
- WRITE:
  - winc = !wfull && !wrst (combinational); wdata = data register (registered).
  - If wfull=0 (word accepted at this edge):
    - data += 1, wrapping mod 2^DATASIZE.
    - word_count += 1.
    - If the new word_count == BURST_LENGTH -> DONE.
    - Else if WRITE_PERIOD == 1 -> WRITE.
    - Else -> GAP, with gap counter = WRITE_PERIOD-1.
  - If wfull=1: winc=0, stall_count += 1 (saturating), remain in WRITE. wdata is held, so the stalled word is written once full clears.
- GAP:
  - winc = 0.
  - Gap counter decrements each cycle; -> WRITE on the edge where it reaches 0.
  - GAP lasts exactly WRITE_PERIOD-1 cycles.
- DONE: done = 1 for exactly this one cycle, busy = 1, winc = 0; -> IDLE.
- abort=1 in WRITE or GAP:
  - -> IDLE at the next edge; abort overrides the WRITE-state transition.
  - winc still follows the WRITE rule in the abort cycle, so a word accepted in that cycle is counted.
  - No done pulse; word_count and stall_count hold their values.
- abort in IDLE or DONE has no effect.
- Latency: start sampled at edge 0 -> first winc in cycle 1.
- Unstalled burst: last write in cycle 1+(BURST_LENGTH-1)*WRITE_PERIOD; done in the following cycle.
- Write-gating invariant: winc is never high while wfull is high or outside WRITE.

Test Plan:
- Defaults, wfull=0, start pulse at cycle 0 -> winc high in odd cycles 1..2047; wdata sequence 0x00..0xFF repeated 4 times; done in cycle 2048; word_count=1024; stall_count=0; busy low from cycle 2049.
- WRITE_PERIOD=1, BURST_LENGTH=16, SEED=0xF8 -> winc in cycles 1..16; wdata 0xF8..0xFF then 0x00..0x07; done in cycle 17.
- wfull held high for 5 cycles when the 10th word is presented -> winc low for those 5 cycles; word 0x09 written exactly once after wfull falls; stall_count=5; completion delayed by 5 cycles; scoreboard shows no loss or duplication.
- abort asserted in GAP after 100 accepted words -> IDLE next cycle; no done; word_count=100. A new start then restarts at SEED with word_count=0 and stall_count=0.
- wrst asserted for 1 cycle mid-burst in WRITE with wfull=0 -> winc=0 in that cycle; all outputs back to reset values; start while busy has no effect on data or counters.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// Write-side burst traffic source for an asynchronous FIFO write port.
// Emits BURST_LENGTH words spaced WRITE_PERIOD cycles apart, stalling on wfull.
module fifo_burst_writer #(
   parameter int unsigned DATASIZE     = 8,
   parameter int unsigned BURST_LENGTH = 1024,
   parameter int unsigned WRITE_PERIOD = 2,
   parameter int unsigned SEED         = 0
) (
   input  logic                                wclk,
   input  logic                                wrst,
   input  logic                                start,
   input  logic                                abort,
   input  logic                                wfull,
   output logic                                winc,
   output logic [DATASIZE-1:0]                 wdata,
   output logic                                busy,
   output logic                                done,
   output logic [$clog2(BURST_LENGTH+1)-1:0]   word_count,
   output logic [15:0]                         stall_count
);

   localparam int unsigned WCW = $clog2(BURST_LENGTH + 1);
   localparam int unsigned GW  = (WRITE_PERIOD > 1) ? $clog2(WRITE_PERIOD) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [DATASIZE-1:0] SEED_V   = DATASIZE'(SEED);
   localparam logic [WCW-1:0]      LAST_IDX = WCW'(BURST_LENGTH - 1);
   localparam logic [GW-1:0]       GAP_INIT = GW'(WRITE_PERIOD - 1);

   logic [1:0]          state, state_nxt;
   logic [DATASIZE-1:0] data_nxt;
   logic [WCW-1:0]      wc_nxt;
   logic [15:0]         sc_nxt;
   logic [GW-1:0]       gap, gap_nxt;

   // Write strobe is combinational so a full flag or reset blocks the write in the same cycle.
   assign winc = (state == S_WRITE) && !wfull && !wrst;

   always_comb begin
      state_nxt = state;
      data_nxt  = wdata;
      wc_nxt    = word_count;
      sc_nxt    = stall_count;
      gap_nxt   = gap;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_WRITE;
               data_nxt  = SEED_V;
               wc_nxt    = '0;
               sc_nxt    = '0;
            end
         end
         S_WRITE: begin
            if (!wfull) begin
               data_nxt = wdata + DATASIZE'(1);
               wc_nxt   = word_count + WCW'(1);
               if (word_count == LAST_IDX) begin
                  state_nxt = S_DONE;
               end else if (WRITE_PERIOD == 1) begin
                  state_nxt = S_WRITE;
               end else begin
                  state_nxt = S_GAP;
                  gap_nxt   = GAP_INIT;
               end
            end else if (stall_count != 16'hFFFF) begin
               sc_nxt = stall_count + 16'd1;
            end
            // A word accepted alongside abort is still counted above.
            if (abort) begin
               state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            gap_nxt = gap - GW'(1);
            if (gap == GW'(1)) begin
               state_nxt = S_WRITE;
            end
            if (abort) begin
               state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state       <= S_IDLE;
         wdata       <= SEED_V;
         word_count  <= '0;
         stall_count <= '0;
         gap         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         wdata       <= data_nxt;
         word_count  <= wc_nxt;
         stall_count <= sc_nxt;
         gap         <= gap_nxt;
         busy        <= (state_nxt != S_IDLE);
         done        <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: scoreboarded write data plus cycle-exact checks
// for the default burst, back-to-back burst, stall, abort and mid-burst reset.
module tb_fifo_burst_writer;

   logic        wclk = 1'b0;
   logic        wrst;
   logic        start_a, abort_a, wfull_a;
   logic        start_b, abort_b, wfull_b;
   logic        winc_a, busy_a, done_a;
   logic        winc_b, busy_b, done_b;
   logic [7:0]  wdata_a, wdata_b;
   logic [10:0] wc_a;
   logic [4:0]  wc_b;
   logic [15:0] sc_a, sc_b;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];

   typedef struct {
      int   cyc;
      logic winc;
      logic busy;
      logic done;
      int   wc;
   } vec_t;
   vec_t tbl[6];

   always #5 wclk = ~wclk;

   fifo_burst_writer u_a (
      .wclk(wclk), .wrst(wrst), .start(start_a), .abort(abort_a), .wfull(wfull_a),
      .winc(winc_a), .wdata(wdata_a), .busy(busy_a), .done(done_a),
      .word_count(wc_a), .stall_count(sc_a)
   );

   fifo_burst_writer #(.DATASIZE(8), .BURST_LENGTH(16), .WRITE_PERIOD(1), .SEED(32'hF8)) u_b (
      .wclk(wclk), .wrst(wrst), .start(start_b), .abort(abort_b), .wfull(wfull_b),
      .winc(winc_b), .wdata(wdata_b), .busy(busy_b), .done(done_b),
      .word_count(wc_b), .stall_count(sc_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Scoreboards: every accepted write must match the next expected word.
   always @(negedge wclk) begin
      if (winc_a === 1'b1) begin
         chk("a_winc_while_full", wfull_a, 1'b0);
         if (qa.size() == 0) chk("a_unexpected_word", wdata_a, 32'hFFFF_FFFF);
         else chk("a_wdata", wdata_a, qa.pop_front());
      end
      if (winc_b === 1'b1) begin
         if (qb.size() == 0) chk("b_unexpected_word", wdata_b, 32'hFFFF_FFFF);
         else chk("b_wdata", wdata_b, qb.pop_front());
      end
   end

   initial begin
      int bad;
      wrst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; wfull_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; wfull_b = 1'b0;
      tbl[0] = '{1,    1'b1, 1'b1, 1'b0, 0};
      tbl[1] = '{2,    1'b0, 1'b1, 1'b0, 1};
      tbl[2] = '{3,    1'b1, 1'b1, 1'b0, 1};
      tbl[3] = '{2047, 1'b1, 1'b1, 1'b0, 1023};
      tbl[4] = '{2048, 1'b0, 1'b1, 1'b1, 1024};
      tbl[5] = '{2049, 1'b0, 1'b0, 1'b0, 1024};

      repeat (2) @(posedge wclk);
      #1 wrst = 1'b0;
      @(negedge wclk);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_winc", winc_a, 0);
      chk("rst_wc", wc_a, 0);
      chk("rst_sc", sc_a, 0);
      chk("rst_wdata_a", wdata_a, 8'h00);
      chk("rst_wdata_b", wdata_b, 8'hF8);

      // Default burst, no stalls
      @(posedge wclk); #1 start_a = 1'b1;
      for (int i = 0; i < 1024; i++) qa.push_back(8'(i));
      @(posedge wclk); #1 start_a = 1'b0;
      bad = 0;
      for (int c = 1; c <= 2050; c++) begin
         @(negedge wclk);
         if (winc_a !== ((c % 2 == 1) && c <= 2047)) bad++;
         foreach (tbl[i]) begin
            if (tbl[i].cyc == c) begin
               chk($sformatf("dflt_winc_c%0d", c), winc_a, tbl[i].winc);
               chk($sformatf("dflt_busy_c%0d", c), busy_a, tbl[i].busy);
               chk($sformatf("dflt_done_c%0d", c), done_a, tbl[i].done);
               chk($sformatf("dflt_wc_c%0d", c), wc_a, tbl[i].wc);
            end
         end
         if (c == 2049) chk("dflt_sc", sc_a, 0);
         @(posedge wclk); #1;
      end
      chk("dflt_winc_pattern_errors", bad, 0);
      chk("dflt_queue_left", qa.size(), 0);

      // Back-to-back burst with wrapping seed
      start_b = 1'b1;
      for (int i = 0; i < 16; i++) qb.push_back(8'(8'hF8 + i));
      @(posedge wclk); #1 start_b = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge wclk);
         chk($sformatf("b_winc_c%0d", c), winc_b, (c <= 16));
         chk($sformatf("b_done_c%0d", c), done_b, (c == 17));
         @(posedge wclk); #1;
      end
      chk("b_wc", wc_b, 16);
      chk("b_sc", sc_b, 0);
      chk("b_queue_left", qb.size(), 0);

      // Five-cycle full stall on the 10th word
      start_a = 1'b1;
      for (int i = 0; i < 1024; i++) qa.push_back(8'(i));
      @(posedge wclk); #1 start_a = 1'b0;
      for (int c = 1; c <= 2055; c++) begin
         wfull_a = (c >= 19 && c <= 23);
         @(negedge wclk);
         if (c >= 19 && c <= 23) chk($sformatf("stall_winc_c%0d", c), winc_a, 0);
         if (c == 24) begin
            chk("stall_resume_winc", winc_a, 1);
            chk("stall_resume_wdata", wdata_a, 8'h09);
         end
         if (c == 2052) chk("stall_done_early", done_a, 0);
         if (c == 2053) chk("stall_done", done_a, 1);
         if (c == 2054) begin
            chk("stall_sc", sc_a, 5);
            chk("stall_wc", wc_a, 1024);
            chk("stall_busy", busy_a, 0);
         end
         @(posedge wclk); #1;
      end
      chk("stall_queue_left", qa.size(), 0);

      // Abort in GAP after 100 words (with 3 stall cycles early on)
      start_a = 1'b1;
      for (int i = 0; i < 1024; i++) qa.push_back(8'(i));
      @(posedge wclk); #1 start_a = 1'b0;
      for (int c = 1; c <= 206; c++) begin
         wfull_a = (c >= 3 && c <= 5);
         abort_a = (c == 203);
         @(negedge wclk);
         if (c >= 200) chk($sformatf("abort_no_done_c%0d", c), done_a, 0);
         if (c == 203) begin
            chk("abort_gap_winc", winc_a, 0);
            chk("abort_gap_busy", busy_a, 1);
         end
         if (c == 204) begin
            chk("abort_busy", busy_a, 0);
            chk("abort_wc", wc_a, 100);
            chk("abort_sc", sc_a, 3);
         end
         @(posedge wclk); #1;
      end
      chk("abort_queue_left", qa.size(), 924);
      qa.delete();

      // Restart, ignored start while busy, then reset mid-burst
      start_a = 1'b1;
      for (int i = 0; i < 1024; i++) qa.push_back(8'(i));
      @(posedge wclk); #1 start_a = 1'b0;
      for (int c = 1; c <= 55; c++) begin
         start_a = (c == 10 || c == 11);
         wrst    = (c == 51);
         @(negedge wclk);
         if (c == 1) begin
            chk("restart_wc", wc_a, 0);
            chk("restart_sc", sc_a, 0);
            chk("restart_busy", busy_a, 1);
         end
         if (c == 13) chk("busy_start_wc", wc_a, 6);
         if (c == 51) chk("rst_mid_winc", winc_a, 0);
         if (c == 52) begin
            chk("rst_mid_busy", busy_a, 0);
            chk("rst_mid_done", done_a, 0);
            chk("rst_mid_wc", wc_a, 0);
            chk("rst_mid_sc", sc_a, 0);
            chk("rst_mid_wdata", wdata_a, 8'h00);
            chk("rst_mid_winc_after", winc_a, 0);
         end
         @(posedge wclk); #1;
      end
      chk("rst_queue_left", qa.size(), 999);
      qa.delete();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
